// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, derived totals,
// and the sync polarity type used by vga_timing_gen.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_PULSE  = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_PULSE  = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_BLANK  = VGA_H_FP + VGA_H_PULSE + VGA_H_BP;
  localparam int VGA_H_TOTAL  = VGA_H_BLANK + VGA_H_ACTIVE;
  localparam int VGA_V_BLANK  = VGA_V_FP + VGA_V_PULSE + VGA_V_BP;
  localparam int VGA_V_TOTAL  = VGA_V_BLANK + VGA_V_ACTIVE;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } pol_e;

  // Drive level of a sync line given its polarity and whether it is asserted.
  function automatic logic sync_level(input pol_e pol, input logic asserted);
    return asserted ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Horizontal/vertical raster wrap counter with a configurable reset-load
// position. Exposes both the registered count and the value it takes at
// the next edge so callers can register decodes with zero skew.
module vga_scan_counter #(
  parameter int CNT_W   = 10,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] hc_o,
  output logic [CNT_W-1:0] vc_o,
  output logic [CNT_W-1:0] hc_next_o,
  output logic [CNT_W-1:0] vc_next_o,
  output logic             frame_wrap_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_RST  = CNT_W'(H_INIT);
  localparam logic [CNT_W-1:0] V_RST  = CNT_W'(V_INIT);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             wrap_d;

  // Next count: reset load is folded in so downstream decodes see it too.
  always_comb begin
    hc_d   = hc_q;
    vc_d   = vc_q;
    wrap_d = 1'b0;
    if (!rstn_i) begin
      hc_d = H_RST;
      vc_d = V_RST;
    end else if (en_i) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d   = '0;
          wrap_d = 1'b1;
        end else begin
          vc_d = vc_q + CNT_W'(1);
        end
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
    end
  end

  // Count registers with synchronous reset to the load position.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hc_q <= H_RST;
      vc_q <= V_RST;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o         = hc_q;
  assign vc_o         = vc_q;
  assign hc_next_o    = hc_d;
  assign vc_next_o    = vc_d;
  assign frame_wrap_o = wrap_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync, display enable, pixel coordinates,
// line/frame markers and frame counter. Every output is a flop decoded from
// the next-state scan count, so all of them describe hc_o/vc_o together.
// Optional feature macro: VGA_TIMING_LOOKAHEAD_EN adds fetch_* outputs that
// lead the display outputs by LOOKAHEAD enabled pixel steps.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_PULSE   = VGA_H_PULSE,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_PULSE   = VGA_V_PULSE,
  parameter int V_BP      = VGA_V_BP,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8,
  parameter int LOOKAHEAD = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               pix_en_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               activevideo_o,
  output logic [CNT_W-1:0]   x_px_o,
  output logic [CNT_W-1:0]   y_px_o,
  output logic [CNT_W-1:0]   hc_o,
  output logic [CNT_W-1:0]   vc_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic [FRAME_W-1:0] frame_cnt_o
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic               fetch_active_o,
  output logic [CNT_W-1:0]   fetch_x_o,
  output logic [CNT_W-1:0]   fetch_y_o
`endif
);

  localparam int H_BLANK = H_FP + H_PULSE + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_PULSE + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  localparam pol_e HPOL = pol_e'(H_POL);
  localparam pol_e VPOL = pol_e'(V_POL);

  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_FP + H_PULSE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_FP + V_PULSE);
  localparam logic [CNT_W-1:0] H_BLANK_C  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_C  = CNT_W'(V_BLANK);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  if (LOOKAHEAD < 1 || LOOKAHEAD >= H_TOTAL ||
      (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("vga_timing_gen: illegal LOOKAHEAD or CNT_W too narrow");
  end

  // ---------------------------------------------------------------------
  // Display scan counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] hc_nxt, vc_nxt;
  logic             frame_wrap;

  vga_scan_counter #(
    .CNT_W   (CNT_W),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (0),
    .V_INIT  (0)
  ) u_disp_cnt (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (pix_en_i),
    .hc_o         (hc_o),
    .vc_o         (vc_o),
    .hc_next_o    (hc_nxt),
    .vc_next_o    (vc_nxt),
    .frame_wrap_o (frame_wrap)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // Decode display outputs from the count that will be current next cycle.
  always_comb begin
    hsync_d     = sync_level(HPOL, (hc_nxt >= H_SYNC_BEG) && (hc_nxt < H_SYNC_END));
    vsync_d     = sync_level(VPOL, (vc_nxt >= V_SYNC_BEG) && (vc_nxt < V_SYNC_END));
    active_d    = (hc_nxt >= H_BLANK_C) && (vc_nxt >= V_BLANK_C);
    x_d         = '0;
    y_d         = '0;
    if (active_d) begin
      x_d = hc_nxt - H_BLANK_C;
      y_d = vc_nxt - V_BLANK_C;
    end
    eol_d       = (hc_nxt == H_LAST);
    eof_d       = eol_d && (vc_nxt == V_LAST);
    frame_cnt_d = frame_cnt_q + FRAME_W'(frame_wrap);
  end

  // Display output registers; holding is implicit since the next count
  // equals the current one when pix_en_i is low.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      active_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      active_q    <= active_d;
      x_q         <= x_d;
      y_q         <= y_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign activevideo_o = active_q;
  assign x_px_o        = x_q;
  assign y_px_o        = y_q;
  assign eol_o         = eol_q;
  assign eof_o         = eof_q;
  assign frame_cnt_o   = frame_cnt_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  // ---------------------------------------------------------------------
  // Lookahead scan counter: starts LOOKAHEAD steps ahead and advances in
  // lockstep, so wrap behaviour matches the display counter exactly.
  // ---------------------------------------------------------------------
  localparam bit               FA_RST = (LOOKAHEAD >= H_BLANK) && (V_BLANK == 0);
  localparam logic [CNT_W-1:0] FX_RST = FA_RST ? CNT_W'(LOOKAHEAD - H_BLANK) : '0;

  logic [CNT_W-1:0] la_hc, la_vc, la_hc_nxt, la_vc_nxt;
  logic             la_wrap;
  logic             unused_la;

  vga_scan_counter #(
    .CNT_W   (CNT_W),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (LOOKAHEAD),
    .V_INIT  (0)
  ) u_fetch_cnt (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (pix_en_i),
    .hc_o         (la_hc),
    .vc_o         (la_vc),
    .hc_next_o    (la_hc_nxt),
    .vc_next_o    (la_vc_nxt),
    .frame_wrap_o (la_wrap)
  );

  assign unused_la = ^{la_hc, la_vc, la_wrap};

  logic             fetch_active_q, fetch_active_d;
  logic [CNT_W-1:0] fetch_x_q, fetch_x_d;
  logic [CNT_W-1:0] fetch_y_q, fetch_y_d;

  // Decode fetch coordinates from the lookahead counter's next count.
  always_comb begin
    fetch_active_d = (la_hc_nxt >= H_BLANK_C) && (la_vc_nxt >= V_BLANK_C);
    fetch_x_d      = '0;
    fetch_y_d      = '0;
    if (fetch_active_d) begin
      fetch_x_d = la_hc_nxt - H_BLANK_C;
      fetch_y_d = la_vc_nxt - V_BLANK_C;
    end
  end

  // Fetch output registers; reset values are the decode of (LOOKAHEAD, 0).
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_active_q <= FA_RST;
      fetch_x_q      <= FX_RST;
      fetch_y_q      <= '0;
    end else begin
      fetch_active_q <= fetch_active_d;
      fetch_x_q      <= fetch_x_d;
      fetch_y_q      <= fetch_y_d;
    end
  end

  assign fetch_active_o = fetch_active_q;
  assign fetch_x_o      = fetch_x_q;
  assign fetch_y_o      = fetch_y_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a small custom raster so
// several whole frames fit in a short run. The reference tracks only the
// number of enabled pixel steps since reset and derives every output from
// it arithmetically.
module tb_vga_timing_gen;

  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HP  = 3;
  localparam int HBP = 2;
  localparam int VA  = 6;
  localparam int VF  = 1;
  localparam int VP  = 2;
  localparam int VBP = 2;
  localparam int HBL = HF + HP + HBP;
  localparam int HT  = HBL + HA;
  localparam int VBL = VF + VP + VBP;
  localparam int VT  = VBL + VA;
  localparam int CW  = 6;
  localparam int FW  = 2;
  localparam int LA  = 3;
  localparam int HPOL = 1;
  localparam int VPOL = 0;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pix_en;
  logic          hsync, vsync, active, eol, eof;
  logic [CW-1:0] x_px, y_px, hc, vc;
  logic [FW-1:0] frame_cnt;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic          f_active;
  logic [CW-1:0] f_x, f_y;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HF),
    .H_PULSE   (HP),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VF),
    .V_PULSE   (VP),
    .V_BP      (VBP),
    .H_POL     (1'b1),
    .V_POL     (1'b0),
    .CNT_W     (CW),
    .FRAME_W   (FW),
    .LOOKAHEAD (LA)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .pix_en_i       (pix_en),
    .hsync_o        (hsync),
    .vsync_o        (vsync),
    .activevideo_o  (active),
    .x_px_o         (x_px),
    .y_px_o         (y_px),
    .hc_o           (hc),
    .vc_o           (vc),
    .eol_o          (eol),
    .eof_o          (eof),
    .frame_cnt_o    (frame_cnt)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    .fetch_active_o (f_active),
    .fetch_x_o      (f_x),
    .fetch_y_o      (f_y)
`endif
  );

  int    checks   = 0;
  int    failures = 0;
  longint steps   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare every output against the raster position reached after s steps.
  task automatic check_model(input longint s);
    int hcx, vcx, frx;
    int lh, lv;
    bit act, fact;
    hcx = int'(s % HT);
    vcx = int'((s / HT) % VT);
    frx = int'((s / (HT * VT)) % (1 << FW));
    act = (hcx >= HBL) && (vcx >= VBL);
    chk("hc", hc, hcx);
    chk("vc", vc, vcx);
    chk("frame_cnt", frame_cnt, frx);
    chk("hsync", hsync, (hcx >= HF && hcx < HF + HP) ? HPOL : 1 - HPOL);
    chk("vsync", vsync, (vcx >= VF && vcx < VF + VP) ? VPOL : 1 - VPOL);
    chk("active", active, act);
    chk("x", x_px, act ? hcx - HBL : 0);
    chk("y", y_px, act ? vcx - VBL : 0);
    chk("eol", eol, hcx == HT - 1);
    chk("eof", eof, (hcx == HT - 1) && (vcx == VT - 1));
    lh   = int'((s + LA) % HT);
    lv   = int'(((s + LA) / HT) % VT);
    fact = (lh >= HBL) && (lv >= VBL);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk("fetch_active", f_active, fact);
    chk("fetch_x", f_x, fact ? lh - HBL : 0);
    chk("fetch_y", f_y, fact ? lv - VBL : 0);
`endif
  endtask

  // Apply inputs for one clock, advance the reference, check on negedge.
  task automatic step(input bit r, input bit e);
    rstn   = r;
    pix_en = e;
    @(posedge clk);
    if (!r)     steps = 0;
    else if (e) steps++;
    @(negedge clk);
    check_model(steps);
  endtask

  initial begin
    rstn   = 1'b0;
    pix_en = 1'b0;

    // Reset holds regardless of enable.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 1);

    // First cycle after release still shows the origin.
    step(1'b1, 1'b0);
    chk("rel_hc", hc, 0);

    // First active pixel lands H_BLANK + V_BLANK*H_TOTAL steps after reset.
    for (int i = 0; i < HBL + VBL * HT - 1; i++) step(1'b1, 1'b1);
    chk("pre_first_active", active, 0);
    step(1'b1, 1'b1);
    chk("first_active", active, 1);
    chk("first_hc", hc, HBL);
    chk("first_vc", vc, VBL);
    chk("first_x", x_px, 0);
    chk("first_y", y_px, 0);

    // Several full frames: frame counter wraps 3 -> 0 along the way.
    for (int i = 0; i < 5 * HT * VT; i++) step(1'b1, 1'b1);
    chk("frame_after_5", frame_cnt, 1);

    // Enable toggling: counters step every other clock and hold in between.
    for (int i = 0; i < 4 * HT; i++) step(1'b1, (i % 2) == 0);

    // Random enables with occasional mid-frame resets.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

    // Directed mid-frame reset with enable low.
    for (int i = 0; i < HT * VT; i++) begin
      if ((steps % HT) == 9 && ((steps / HT) % VT) == 4) break;
      step(1'b1, 1'b1);
    end
    chk("pre_reset_hc", hc, 9);
    chk("pre_reset_vc", vc, 4);
    step(1'b0, 1'b0);
    chk("mid_reset_hc", hc, 0);
    chk("mid_reset_vc", vc, 0);
    chk("mid_reset_frame", frame_cnt, 0);
    step(1'b1, 1'b1);
    chk("restart_hc", hc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: scan counters, sync pulses, display-enable, pixel coordinates, line/frame markers and a frame counter for any standard or custom mode. Sits between the pixel-clock domain's clock enable and the pixel pipeline (framebuffer/tile fetch, colour mux). Sync polarity and all porch/pulse lengths are per-instance parameters. An optional lookahead coordinate port lets memory fetch run ahead of display.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_PULSE, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_PULSE, 2, vsync width
- V_BP, 33, vertical back porch
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width
- LOOKAHEAD, 2, lead of fetch outputs in pixel steps; 1 ≤ LOOKAHEAD < H_TOTAL

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  synchronous reset, active-low
- pix_en_i  in  1  pixel step enable; counters advance only when high
- hsync_o  out  1  horizontal sync, polarity H_POL
- vsync_o  out  1  vertical sync, polarity V_POL
- activevideo_o  out  1  display enable
- x_px_o  out  CNT_W  active-area column, 0 outside active
- y_px_o  out  CNT_W  active-area row, 0 outside active
- hc_o  out  CNT_W  horizontal counter
- vc_o  out  CNT_W  vertical counter
- eol_o  out  1  high while hc_o == H_TOTAL-1
- eof_o  out  1  high while hc_o == H_TOTAL-1 and vc_o == V_TOTAL-1
- frame_cnt_o  out  FRAME_W  completed-frame count, wraps
- fetch_active_o, fetch_x_o, fetch_y_o  out  1/CNT_W/CNT_W  lookahead copies (macro-gated)

## Operation
- H_BLANK = H_FP+H_PULSE+H_BP, H_TOTAL = H_BLANK+H_ACTIVE; V likewise. Defaults: 800 x 525.
- Line layout: front porch at hc 0..H_FP-1, sync, back porch, active at hc H_BLANK..H_TOTAL-1. Same for vertical.
- pix_en_i high: hc increments; at H_TOTAL-1 wraps to 0 and vc increments; vc wraps V_TOTAL-1 → 0 and frame_cnt_o increments (modulo 2^FRAME_W).
- pix_en_i low: every output holds.
- hsync active for H_FP ≤ hc < H_FP+H_PULSE; vsync active for V_FP ≤ vc < V_FP+V_PULSE.
- activevideo_o = (hc ≥ H_BLANK) and (vc ≥ V_BLANK); then x = hc-H_BLANK, y = vc-V_BLANK, else both 0.
- All subtraction in CNT_W bits; no overflow within legal ranges.

## Timing
- All outputs are flops, decoded from next-state counters. No output comes straight from combinational logic off the current count.
- hsync_o, vsync_o, activevideo_o, x/y, eol_o and eof_o all describe the same hc_o/vc_o value in the same cycle. Zero skew between them.
- Reset, and the first cycle after release: hc=vc=0, frame_cnt=0, sync outputs inactive (~H_POL/~V_POL), activevideo_o=0, x=y=0, eol_o=eof_o=0.
- Reset asserted mid-frame: all outputs take reset values on the next edge, regardless of pix_en_i.
- Reset overrides pix_en_i.
- The first active pixel after reset comes H_BLANK + V_BLANK·H_TOTAL enabled steps later.

## Configuration
- VGA_TIMING_LOOKAHEAD_EN defined:
  - A second scan counter pair drives the fetch_* outputs.
  - It resets to hc=LOOKAHEAD, vc=0 and advances with pix_en_i.
  - fetch_* therefore equal the activevideo/x/y values that appear LOOKAHEAD enabled steps later, including across line and frame wrap.
- Macro undefined: fetch_* ports are absent and there is no second counter.

## Structure
- Shared package vga_pkg: default 640x480@60 timing constants, derived H_TOTAL/V_TOTAL/H_BLANK/V_BLANK, and a polarity enum.
- One sub-module, vga_scan_counter, holds the hc/vc wrap counters with a reset-load value. It is instantiated once for display and once for lookahead.

## Test plan
- Defaults, reset, pix_en_i=1 → hsync_o low exactly for hc_o 16..111; first activevideo_o at hc_o=160, vc_o=45 with x=0, y=0; x=639 at hc_o=799.
- Run a full frame → eof_o high for one cycle at (799,524); then hc=vc=0 and frame_cnt_o 0→1; with FRAME_W=2, 3→0 wrap.
- pix_en_i toggled 1/0 → counters step every other cycle, outputs stable on low cycles, line length 1600 clocks.
- rstn_i low at hc=300, vc=200 → next cycle all reset values; restart from (0,0).
- H_POL=1, V_POL=1 → hsync high only at hc 16..111; vsync high only at vc 10..11.
- Macro on, LOOKAHEAD=2 → fetch_x_o=0 and fetch_active_o=1 when hc_o=158, vc_o=45; fetch_x_o=0, fetch_y_o=0 at hc_o=798, vc_o=524.
